// File: rtl/regfile_cmd_master_if.sv
// Register-file command bus bundle.
// Groups the UART byte stream, the register-file strobe/response pair and
// the status flags that connect the command master to its neighbours.
//   master modport : the command master (drives strobes, TX byte, status)
//   slave modport  : the surroundings (UART RX/TX side and register file)
// Signals:
//   RX_P_DATA/RX_D_VLD     received byte and its one-cycle valid pulse
//   WrEn/RdEn/Address/WrData register-file strobes, address, write data
//   RdData/RdData_VLD/wr_done register-file responses
//   TX_P_DATA/TX_D_VLD/TX_BUSY byte to the transmitter and its flow control
//   busy/cmd_err           master status
interface regfile_cmd_master_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdData_VLD;
    logic                  wr_done;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  TX_BUSY;
    logic                  busy;
    logic                  cmd_err;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, wr_done, TX_BUSY,
        output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, busy, cmd_err
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, wr_done, TX_BUSY,
        input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, busy, cmd_err
    );
endinterface

// File: rtl/regfile_cmd_master.sv
// Register-file command master.
// Parses UART command frames (write: opcode, address, data; read: opcode,
// address), issues single-cycle register-file strobes, waits for the
// matching acknowledge with a bounded timeout and forwards read data to the
// UART transmitter.
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-high reset
//   bus  regfile_cmd_master_if master modport (all outputs registered)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an opcode byte
// WR_ADDR | write frame, waiting for the address byte
// WR_DATA | write frame, waiting for the data byte
// WR_WAIT | WrEn issued, waiting for wr_done (bounded)
// RD_ADDR | read frame, waiting for the address byte
// RD_WAIT | RdEn issued, waiting for RdData_VLD (bounded)
// TX_SEND | read data held, waiting for the transmitter to be free
module regfile_cmd_master #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           ADDR_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_WR      = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] CMD_RD      = 8'hBB,
    parameter int unsigned           RSP_TIMEOUT = 15
) (
    input logic                  CLK,
    input logic                  RST,
    regfile_cmd_master_if.master bus
);
    localparam int unsigned      CNT_W    = $clog2(RSP_TIMEOUT + 1);
    // The counter starts at 0 on the strobe edge, so the abort edge is the
    // one where it already holds RSP_TIMEOUT-1: cmd_err then lands exactly
    // RSP_TIMEOUT cycles after the strobe.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_WAIT,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [CNT_W-1:0]      cnt;
    logic                  addr_ok;

    assign addr_ok = (bus.RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH] == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            addr_q        <= '0;
            tx_q          <= '0;
            cnt           <= '0;
            bus.WrEn      <= 1'b0;
            bus.RdEn      <= 1'b0;
            bus.Address   <= '0;
            bus.WrData    <= '0;
            bus.TX_P_DATA <= '0;
            bus.TX_D_VLD  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.cmd_err   <= 1'b0;
        end else begin
            bus.WrEn     <= 1'b0;
            bus.RdEn     <= 1'b0;
            bus.TX_D_VLD <= 1'b0;
            bus.cmd_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.RX_D_VLD) begin
                        if (bus.RX_P_DATA == CMD_WR) begin
                            state    <= WR_ADDR;
                            bus.busy <= 1'b1;
                        end else if (bus.RX_P_DATA == CMD_RD) begin
                            state    <= RD_ADDR;
                            bus.busy <= 1'b1;
                        end else begin
                            bus.cmd_err <= 1'b1;
                        end
                    end
                end

                WR_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        if (addr_ok) begin
                            addr_q <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                            state  <= WR_DATA;
                        end else begin
                            bus.cmd_err <= 1'b1;
                            bus.busy    <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end

                WR_DATA: begin
                    if (bus.RX_D_VLD) begin
                        bus.WrEn    <= 1'b1;
                        bus.Address <= addr_q;
                        bus.WrData  <= bus.RX_P_DATA;
                        cnt         <= '0;
                        state       <= WR_WAIT;
                    end
                end

                WR_WAIT: begin
                    if (bus.RX_D_VLD) begin
                        bus.cmd_err <= 1'b1;
                    end
                    if (bus.wr_done) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        bus.cmd_err <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RD_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        if (addr_ok) begin
                            bus.RdEn    <= 1'b1;
                            bus.Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                            cnt         <= '0;
                            state       <= RD_WAIT;
                        end else begin
                            bus.cmd_err <= 1'b1;
                            bus.busy    <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end

                RD_WAIT: begin
                    if (bus.RX_D_VLD) begin
                        bus.cmd_err <= 1'b1;
                    end
                    if (bus.RdData_VLD) begin
                        tx_q  <= bus.RdData;
                        state <= TX_SEND;
                    end else if (cnt == CNT_LAST) begin
                        bus.cmd_err <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                TX_SEND: begin
                    if (bus.RX_D_VLD) begin
                        bus.cmd_err <= 1'b1;
                    end
                    // No timeout here: the transmitter always drains eventually.
                    if (!bus.TX_BUSY) begin
                        bus.TX_P_DATA <= tx_q;
                        bus.TX_D_VLD  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_cmd_master.sv
// Self-checking bench for regfile_cmd_master: a register-file/UART model
// responds to the strobes, a scoreboard queue holds the expected WrEn, RdEn,
// TX and cmd_err events in order, and the main sequence checks latencies.
module tb_regfile_cmd_master;
    localparam int EV_WR  = 1;
    localparam int EV_RD  = 2;
    localparam int EV_TX  = 3;
    localparam int EV_ERR = 4;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    logic CLK;
    logic RST;

    regfile_cmd_master_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    regfile_cmd_master #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .CMD_WR     (8'hAA),
        .CMD_RD     (8'hBB),
        .RSP_TIMEOUT(15)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   n_chk  = 0;
    int   n_pass = 0;
    ev_t  sb_q[$];
    int   cyc = 0;
    int   rdvld_cyc = 0;
    int   tx_cyc = 0;

    int   wr_lat = 2;
    int   rd_lat = 1;
    bit   rd_resp_en = 1'b1;
    int   wr_pend = 0;
    int   rd_pend = 0;
    logic [7:0] rd_val = 8'h00;
    logic [7:0] mem [16];

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic sb_push(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_unexpected_event", kind, 0);
        end else begin
            e = sb_q.pop_front();
            check_val("sb_kind", kind, e.kind);
            if (kind == e.kind) begin
                if (kind == EV_WR) begin
                    check_val("wr_addr", a, e.a);
                    check_val("wr_data", d, e.d);
                end else if (kind == EV_RD) begin
                    check_val("rd_addr", a, e.a);
                end else if (kind == EV_TX) begin
                    check_val("tx_data", d, e.d);
                end
            end
        end
    endtask

    // Output monitor: sampled 1 time unit after each rising edge.
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (!RST) begin
            if (bus.WrEn && bus.RdEn) check_val("wren_rden_overlap", 1, 0);
            if (bus.RdData_VLD) rdvld_cyc = cyc;
            if (bus.WrEn)     sb_pop(EV_WR, {4'h0, bus.Address}, bus.WrData);
            if (bus.RdEn)     sb_pop(EV_RD, {4'h0, bus.Address}, 8'h00);
            if (bus.TX_D_VLD) begin
                tx_cyc = cyc;
                sb_pop(EV_TX, 8'h00, bus.TX_P_DATA);
            end
            if (bus.cmd_err)  sb_pop(EV_ERR, 8'h00, 8'h00);
        end
    end

    // Register-file model: responds on falling edges.
    always @(negedge CLK) begin
        bus.wr_done    = 1'b0;
        bus.RdData_VLD = 1'b0;
        if (RST) begin
            wr_pend = 0;
            rd_pend = 0;
            for (int i = 0; i < 16; i++) mem[i] = 8'h00;
            mem[2] = 8'h81;
            mem[3] = 8'hC3;
        end else begin
            if (wr_pend > 0) begin
                wr_pend--;
                if (wr_pend == 0) bus.wr_done = 1'b1;
            end
            if (rd_pend > 0) begin
                rd_pend--;
                if (rd_pend == 0) begin
                    bus.RdData_VLD = 1'b1;
                    bus.RdData     = rd_val;
                end
            end
            if (bus.WrEn) begin
                mem[bus.Address] = bus.WrData;
                if (wr_lat == 0) bus.wr_done = 1'b1;
                else wr_pend = wr_lat;
            end
            if (bus.RdEn && rd_resp_en) begin
                rd_val = mem[bus.Address];
                if (rd_lat == 0) begin
                    bus.RdData_VLD = 1'b1;
                    bus.RdData     = rd_val;
                end else begin
                    rd_pend = rd_lat;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(negedge CLK);
        bus.RX_D_VLD  = 1'b0;
    endtask

    function automatic logic sig_hit(input int sel);
        case (sel)
            0:       return !bus.busy;
            1:       return bus.TX_D_VLD;
            default: return bus.cmd_err;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int max, output int n);
        n = 0;
        while (n < max && !sig_hit(sel)) begin
            @(negedge CLK);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;

        RST            = 1'b1;
        bus.RX_P_DATA  = 8'h00;
        bus.RX_D_VLD   = 1'b0;
        bus.TX_BUSY    = 1'b0;
        bus.RdData     = 8'h00;
        bus.RdData_VLD = 1'b0;
        bus.wr_done    = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("rst_busy",     bus.busy,      0);
        check_val("rst_wren",     bus.WrEn,      0);
        check_val("rst_rden",     bus.RdEn,      0);
        check_val("rst_txvld",    bus.TX_D_VLD,  0);
        check_val("rst_cmd_err",  bus.cmd_err,   0);
        check_val("rst_address",  bus.Address,   0);
        check_val("rst_wrdata",   bus.WrData,    0);
        check_val("rst_txdata",   bus.TX_P_DATA, 0);
        RST = 1'b0;
        @(negedge CLK);

        // Write AA,05,3C
        wr_lat = 2;
        sb_push(EV_WR, 8'h05, 8'h3C);
        send_byte(8'hAA);
        check_val("wr_busy_after_op", bus.busy, 1);
        send_byte(8'h05);
        send_byte(8'h3C);
        check_val("wr_latency", bus.WrEn, 1);
        @(negedge CLK);
        check_val("wr_one_cycle", bus.WrEn, 0);
        wait_sig(0, 20, n);
        check_val("wr_busy_low", bus.busy, 0);
        check_val("wr_sb_empty", sb_q.size(), 0);

        // Read BB,02 -> 81
        rd_lat = 1;
        sb_push(EV_RD, 8'h02, 8'h00);
        sb_push(EV_TX, 8'h00, 8'h81);
        send_byte(8'hBB);
        send_byte(8'h02);
        check_val("rd_latency", bus.RdEn, 1);
        @(negedge CLK);
        check_val("rd_one_cycle", bus.RdEn, 0);
        wait_sig(1, 20, n);
        check_val("rd_tx_seen", bus.TX_D_VLD, 1);
        check_val("rd_tx_latency", tx_cyc - rdvld_cyc, 1);
        @(negedge CLK);
        check_val("rd_tx_one_cycle", bus.TX_D_VLD, 0);
        check_val("rd_busy_low", bus.busy, 0);

        // Read with TX backpressure
        bus.TX_BUSY = 1'b1;
        sb_push(EV_RD, 8'h02, 8'h00);
        sb_push(EV_TX, 8'h00, 8'h81);
        send_byte(8'hBB);
        send_byte(8'h02);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.TX_D_VLD) seen = 1'b1;
        end
        check_val("bp_tx_withheld", seen, 0);
        check_val("bp_busy_held", bus.busy, 1);
        bus.TX_BUSY = 1'b0;
        @(negedge CLK);
        check_val("bp_tx_release", bus.TX_D_VLD, 1);
        check_val("bp_tx_data", bus.TX_P_DATA, 8'h81);

        // Bad opcode
        sb_push(EV_ERR, 8'h00, 8'h00);
        send_byte(8'h12);
        check_val("badop_err", bus.cmd_err, 1);
        check_val("badop_busy", bus.busy, 0);
        @(negedge CLK);
        check_val("badop_err_pulse", bus.cmd_err, 0);

        // Illegal address
        sb_push(EV_ERR, 8'h00, 8'h00);
        send_byte(8'hAA);
        send_byte(8'h25);
        check_val("badaddr_err", bus.cmd_err, 1);
        check_val("badaddr_busy", bus.busy, 0);

        // Read timeout
        rd_resp_en = 1'b0;
        sb_push(EV_RD, 8'h03, 8'h00);
        sb_push(EV_ERR, 8'h00, 8'h00);
        send_byte(8'hBB);
        send_byte(8'h03);
        check_val("to_rden", bus.RdEn, 1);
        wait_sig(2, 40, n);
        check_val("to_cycles", n, 15);
        check_val("to_busy_low", bus.busy, 0);
        rd_resp_en = 1'b1;
        @(negedge CLK);

        // Overrun during RD_WAIT
        rd_lat = 4;
        sb_push(EV_RD, 8'h02, 8'h00);
        sb_push(EV_ERR, 8'h00, 8'h00);
        sb_push(EV_TX, 8'h00, 8'h81);
        send_byte(8'hBB);
        send_byte(8'h02);
        send_byte(8'h77);
        check_val("ovr_err", bus.cmd_err, 1);
        check_val("ovr_busy", bus.busy, 1);
        wait_sig(1, 20, n);
        check_val("ovr_tx_seen", bus.TX_D_VLD, 1);
        check_val("ovr_tx_data", bus.TX_P_DATA, 8'h81);
        rd_lat = 1;
        @(negedge CLK);

        // Reset mid-frame
        sb_push(EV_ERR, 8'h00, 8'h00);
        send_byte(8'hAA);
        send_byte(8'h07);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_val("midrst_busy", bus.busy, 0);
        RST = 1'b0;
        send_byte(8'h55);
        check_val("midrst_err", bus.cmd_err, 1);
        check_val("midrst_no_wren", bus.WrEn, 0);
        @(negedge CLK);

        // Back-to-back write then read of the same register
        wr_lat = 0;
        sb_push(EV_WR, 8'h09, 8'h5A);
        sb_push(EV_RD, 8'h09, 8'h00);
        sb_push(EV_TX, 8'h00, 8'h5A);
        send_byte(8'hAA);
        send_byte(8'h09);
        send_byte(8'h5A);
        check_val("b2b_wren", bus.WrEn, 1);
        send_byte(8'hBB);
        check_val("b2b_op_accepted", bus.busy, 1);
        send_byte(8'h09);
        check_val("b2b_rden", bus.RdEn, 1);
        wait_sig(1, 20, n);
        check_val("b2b_tx_seen", bus.TX_D_VLD, 1);
        repeat (3) @(negedge CLK);

        check_val("sb_empty_end", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
